// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the execute FSM: reads the synchronous instruction ROM,
// splits each word into fields and presents it over a valid/ready handshake.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for enable
// S_FETCH | issue ROM read at pc when enabled
// S_WAIT  | ROM data returning this cycle, capture it
// S_HOLD  | instruction presented, waiting for execute to accept
// S_HALTED| halt opcode consumed, only a redirect restarts fetch
module instr_fetch_unit #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  output logic [AW-1:0] rom_addr,
  output logic          rom_ce,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    opcode,
  output logic [3:0]    dest,
  output logic [3:0]    select1,
  output logic [3:0]    select2,
  output logic [AW-1:0] instr_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [AW-1:0] instr_pc_nxt;
  logic [15:0]   word, word_nxt;
  logic          valid_nxt;
  logic          halted_nxt;

  assign opcode  = word[15:12];
  assign dest    = word[11:8];
  assign select1 = word[7:4];
  assign select2 = word[3:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      word      <= '0;
      instr_pc  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      word      <= word_nxt;
      instr_pc  <= instr_pc_nxt;
      out_valid <= valid_nxt;
      halted    <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    word_nxt     = word;
    instr_pc_nxt = instr_pc;
    valid_nxt    = out_valid;
    halted_nxt   = halted;
    rom_ce       = 1'b0;
    rom_addr     = '0;

    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (enable) begin
          rom_ce    = 1'b1;
          rom_addr  = pc;
          pc_nxt    = pc + AW'(1);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // pc already points past the word now returning
        word_nxt     = rom_data[15:0];
        instr_pc_nxt = pc - AW'(1);
        valid_nxt    = 1'b1;
        state_nxt    = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          if (opcode == HALT_OP) begin
            state_nxt  = S_HALTED;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Redirect overrides everything: drops in-flight data, flushes or completes
    // the held word, cancels a same-cycle access and any pending halt.
    if (redirect_valid && (state != S_IDLE)) begin
      pc_nxt       = redirect_pc;
      state_nxt    = S_FETCH;
      halted_nxt   = 1'b0;
      valid_nxt    = 1'b0;
      word_nxt     = word;
      instr_pc_nxt = instr_pc;
      rom_ce       = 1'b0;
      rom_addr     = '0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal checks plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_instr_fetch_unit;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] rom_addr, instr_pc;
  logic          rom_ce, out_valid, halted;
  logic [15:0]   rom_data;
  logic [3:0]    opcode, dest, select1, select2;
  logic [15:0]   mem [256];
  int            ntests = 0;
  int            nfail = 0;

  // model state: next fetch address, outstanding read, presented word, halt
  bit            m_started, m_pend, m_pres, m_halt;
  logic [7:0]    m_pc, m_pend_addr, m_pres_addr;
  logic [15:0]   m_word;

  instr_fetch_unit #(.AW(AW), .DW(16), .HALT_OP(4'hF)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .dest(dest), .select1(select1), .select2(select2),
    .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (rom_ce) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare current outputs with the model, then advance it to the next edge
  initial forever begin
    logic ece;
    @(negedge clock);
    if (!reset_n) begin
      m_started = 0; m_pend = 0; m_pres = 0; m_halt = 0; m_pc = '0;
    end
    ece = m_started && enable && !redirect_valid && !m_pend && !m_pres && !m_halt;
    chk("m_rom_ce", 32'(rom_ce), 32'(ece));
    if (ece) chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("m_out_valid", 32'(out_valid), 32'(m_pres));
    chk("m_halted", 32'(halted), 32'(m_halt));
    if (m_pres) begin
      chk("m_opcode", 32'(opcode), 32'(m_word[15:12]));
      chk("m_dest", 32'(dest), 32'(m_word[11:8]));
      chk("m_select1", 32'(select1), 32'(m_word[7:4]));
      chk("m_select2", 32'(select2), 32'(m_word[3:0]));
      chk("m_instr_pc", 32'(instr_pc), 32'(m_pres_addr));
    end
    if (reset_n) begin
      if (!m_started) m_started = enable;
      else if (redirect_valid) begin
        m_pc = redirect_pc; m_pend = 0; m_pres = 0; m_halt = 0;
      end else if (ece) begin
        m_pend = 1; m_pend_addr = m_pc; m_pc = m_pc + 8'd1;
      end else if (m_pend) begin
        m_pend = 0; m_pres = 1; m_word = mem[m_pend_addr]; m_pres_addr = m_pend_addr;
      end else if (m_pres && out_ready) begin
        m_pres = 0;
        if (m_word[15:12] == 4'hF) m_halt = 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_ce"}, 32'(rom_ce), 32'd0);
    chk({name, "_addr"}, 32'(rom_addr), 32'd0);
    chk({name, "_halted"}, 32'(halted), 32'd0);
    chk({name, "_fields"}, 32'({opcode, dest, select1, select2}), 32'd0);
    chk({name, "_ipc"}, 32'(instr_pc), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #1;
    chk_zero("reset");

    // 1: straight-line program ending in halt
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hF000;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("s1_valid", 32'(out_valid), 32'(c == 3 || c == 6 || c == 9));
      chk("s1_ce", 32'(rom_ce), 32'(c == 1 || c == 4 || c == 7));
      chk("s1_halted", 32'(halted), 32'(c >= 10));
      if (c == 3) begin chk("s1_op0", 32'(opcode), 32'h1); chk("s1_pc0", 32'(instr_pc), 32'h0); end
      if (c == 6) begin chk("s1_op1", 32'(opcode), 32'h2); chk("s1_pc1", 32'(instr_pc), 32'h1); end
      if (c == 9) begin chk("s1_op2", 32'(opcode), 32'hF); chk("s1_pc2", 32'(instr_pc), 32'h2); end
    end

    // 2: backpressure holds fields and blocks fetch
    mem[0] = 16'h3A5C; mem[1] = 16'h1111;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    step(); step(); step();
    chk("s2_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s2_hold_valid", 32'(out_valid), 32'd1);
      chk("s2_hold_fields", 32'({opcode, dest, select1, select2}), 32'h3A5C);
      chk("s2_hold_ce", 32'(rom_ce), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("s2_next_ce", 32'(rom_ce), 32'd1);
    chk("s2_next_addr", 32'(rom_addr), 32'h01);
    step(); step(); step();

    // 3: redirect while the read is in flight
    mem[0] = 16'h1000; mem[8'h40] = 16'h5678;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("s3_dropped", 32'(out_valid), 32'd0);
    chk("s3_ce", 32'(rom_ce), 32'd1);
    chk("s3_addr", 32'(rom_addr), 32'h40);
    step(); step();
    chk("s3_valid", 32'(out_valid), 32'd1);
    chk("s3_word", 32'({opcode, dest, select1, select2}), 32'h5678);
    chk("s3_ipc", 32'(instr_pc), 32'h40);

    // 4: redirect during a fetch access, then pc wrap
    mem[8'hFF] = 16'h2000; mem[0] = 16'h3000;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    #1;
    chk("s4_no_access", 32'(rom_ce), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("s4_ce", 32'(rom_ce), 32'd1);
    chk("s4_addr", 32'(rom_addr), 32'hFF);
    step(); step();
    chk("s4_ipc", 32'(instr_pc), 32'hFF);
    step();
    chk("s4_wrap_ce", 32'(rom_ce), 32'd1);
    chk("s4_wrap_addr", 32'(rom_addr), 32'h00);
    step(); step(); step();

    // 5: redirect overrides an accepted halt; redirect out of HALTED
    mem[0] = 16'hF000; mem[8'h10] = 16'h4321; mem[8'h11] = 16'hF000;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    step(); step(); step();
    chk("s5_halt_op", 32'(opcode), 32'hF);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("s5_not_halted", 32'(halted), 32'd0);
    chk("s5_ce", 32'(rom_ce), 32'd1);
    chk("s5_addr", 32'(rom_addr), 32'h10);
    step(); step();
    chk("s5_op", 32'(opcode), 32'h4);
    chk("s5_ipc", 32'(instr_pc), 32'h10);
    step(); step(); step(); step();
    chk("s5_halted", 32'(halted), 32'd1);
    step();
    chk("s5_halted_ce", 32'(rom_ce), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("s5_restart_halted", 32'(halted), 32'd0);
    chk("s5_restart_addr", 32'(rom_addr), 32'h10);
    step(); step(); step();

    // 6: asynchronous reset in WAIT and in HOLD
    mem[0] = 16'h3A5C;
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    step(); step();
    reset_n = 1'b0;
    #1;
    chk_zero("s6_wait");
    step();
    reset_n = 1'b1;
    step();
    chk("s6_ce", 32'(rom_ce), 32'd1);
    chk("s6_addr", 32'(rom_addr), 32'h00);
    step(); step();
    chk("s6_hold_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("s6_hold");
    step();
    reset_n = 1'b1;
    step();
    chk("s6_rel_ce", 32'(rom_ce), 32'd1);
    chk("s6_rel_addr", 32'(rom_addr), 32'h00);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
